// File: rtl/hx711_scale_ctrl.sv
`default_nettype none
// ============================================================================
// hx711_scale_ctrl : tare, block-average, scale and flag HX711 conversions
// Revision 1.0
// ============================================================================
module hx711_scale_ctrl #(
  parameter int AVG_LOG2    = 3,
  parameter int SCALE       = 152,
  parameter int STABLE_TOL  = 16,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        smp_valid,
  input  logic [23:0] smp_data,
  input  logic        tare_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_gramme,
  output logic        out_stable,
  output logic        tare_busy,
  output logic        fault
);

  localparam int c_acc_w = 24 + AVG_LOG2;
  localparam int c_to_w  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYC);

  localparam logic [1:0] S_TARE = 2'd0;
  localparam logic [1:0] S_MEAS = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]          r_state;
  logic [c_acc_w-1:0]  r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [23:0]         r_tare;
  logic [23:0]         r_prev_avg;
  logic                r_has_prev;
  logic                r_tare_pend;
  logic [c_to_w-1:0]   r_to_cnt;

  logic [c_acc_w-1:0]  w_sum;
  logic [23:0]         w_avg;
  logic                w_last;
  logic [24:0]         w_net;
  logic [24:0]         w_diff;
  logic [24:0]         w_absdiff;
  logic [31:0]         w_gram;
  logic                w_stable;

  always_comb begin
    w_sum     = r_acc + {{AVG_LOG2{smp_data[23]}}, smp_data};
    // Top 24 bits of the sum are exactly the arithmetic right shift by AVG_LOG2.
    w_avg     = w_sum[c_acc_w-1:AVG_LOG2];
    w_last    = &r_cnt;
    w_net     = {w_avg[23], w_avg} - {r_tare[23], r_tare};
    w_gram    = {{7{w_net[24]}}, w_net} * 32'(SCALE);
    w_diff    = {w_avg[23], w_avg} - {r_prev_avg[23], r_prev_avg};
    w_absdiff = w_diff[24] ? (25'd0 - w_diff) : w_diff;
    w_stable  = r_has_prev && (w_absdiff <= 25'(STABLE_TOL));
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_TARE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_tare      <= '0;
      r_prev_avg  <= '0;
      r_has_prev  <= 1'b0;
      r_tare_pend <= 1'b0;
      out_valid   <= 1'b0;
      out_gramme  <= '0;
      out_stable  <= 1'b0;
      tare_busy   <= 1'b1;
    end else begin
      case (r_state)
        S_TARE: begin
          if (tare_req) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else if (smp_valid) begin
            if (w_last) begin
              r_tare     <= w_avg;
              r_has_prev <= 1'b0;
              r_acc      <= '0;
              r_cnt      <= '0;
              tare_busy  <= 1'b0;
              r_state    <= S_MEAS;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_MEAS: begin
          if (tare_req) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            tare_busy <= 1'b1;
            r_state   <= S_TARE;
          end else if (smp_valid) begin
            if (w_last) begin
              r_acc      <= '0;
              r_cnt      <= '0;
              out_gramme <= w_gram;
              out_stable <= w_stable;
              r_prev_avg <= w_avg;
              r_has_prev <= 1'b1;
              out_valid  <= 1'b1;
              r_state    <= S_OUT;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_OUT: begin
          // Samples arriving while the result is held are dropped.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_tare_pend || tare_req) begin
              r_tare_pend <= 1'b0;
              tare_busy   <= 1'b1;
              r_state     <= S_TARE;
            end else begin
              r_state <= S_MEAS;
            end
          end else if (tare_req) begin
            r_tare_pend <= 1'b1;
          end
        end
        default: begin
          tare_busy <= 1'b1;
          r_state   <= S_TARE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      fault    <= 1'b0;
    end else if (smp_valid) begin
      r_to_cnt <= '0;
      fault    <= 1'b0;
    end else if (r_to_cnt != c_to_max) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == c_to_max - 1'b1) begin
        fault <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hx711_scale_ctrl.sv
`default_nettype none
// Scoreboard bench for hx711_scale_ctrl: directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_hx711_scale_ctrl;

  localparam int AVG = 2;
  localparam int NB  = 4;
  localparam int SC  = 152;
  localparam int TOL = 16;
  localparam int TO  = 100;

  logic        clk_50 = 1'b0;
  logic        rst_n = 1'b1;
  logic        smp_valid = 1'b0;
  logic [23:0] smp_data = '0;
  logic        tare_req = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_gramme;
  logic        out_stable;
  logic        tare_busy;
  logic        fault;

  hx711_scale_ctrl #(
    .AVG_LOG2(AVG), .SCALE(SC), .STABLE_TOL(TOL), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .smp_valid(smp_valid), .smp_data(smp_data),
    .tare_req(tare_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_gramme(out_gramme), .out_stable(out_stable), .tare_busy(tare_busy),
    .fault(fault)
  );

  always #5 clk_50 = ~clk_50;

  int errors = 0;
  int checks = 0;

  // Reference model: block list, tare value, previous average, pending handshake.
  logic [32:0] exp_q[$];
  longint      blk[$];
  bit          m_tare = 1'b1;
  bit          m_await = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_has_prev = 1'b0;
  longint      m_tarev = 0;
  longint      m_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_sample(input logic [23:0] v);
    longint sum, avg, d;
    if (m_await) return;
    blk.push_back({{40{v[23]}}, v});
    if (blk.size() < NB) return;
    sum = 0;
    foreach (blk[i]) sum += blk[i];
    blk.delete();
    avg = sum >>> AVG;
    if (m_tare) begin
      m_tarev    = avg;
      m_has_prev = 1'b0;
      m_tare     = 1'b0;
    end else begin
      d = avg - m_prev;
      if (d < 0) d = -d;
      exp_q.push_back({1'(m_has_prev && (d <= TOL)), 32'((avg - m_tarev) * SC)});
      m_prev     = avg;
      m_has_prev = 1'b1;
      m_await    = 1'b1;
    end
  endtask

  task automatic model_tare();
    if (m_await) m_pend = 1'b1;
    else begin
      m_tare = 1'b1;
      blk.delete();
    end
  endtask

  task automatic model_reset();
    blk.delete();
    exp_q.delete();
    m_tare = 1'b1; m_await = 1'b0; m_pend = 1'b0;
    m_has_prev = 1'b0; m_tarev = 0; m_prev = 0;
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic send(input logic [23:0] v);
    smp_valid = 1'b1;
    smp_data  = v;
    model_sample(v);
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic send_n(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic tare_pulse();
    tare_req = 1'b1;
    model_tare();
    tick();
    tare_req = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic expect_out(input string name, input logic [31:0] g, input logic s);
    chk({name, "_valid"}, {31'd0, out_valid}, 1);
    chk({name, "_gramme"}, out_gramme, g);
    chk({name, "_stable"}, {31'd0, out_stable}, {31'd0, s});
    drain();
  endtask

  task automatic chk_reset_values();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_gramme", out_gramme, 0);
    chk("rst_out_stable", {31'd0, out_stable}, 0);
    chk("rst_tare_busy", {31'd0, tare_busy}, 1);
    chk("rst_fault", {31'd0, fault}, 0);
  endtask

  // Monitor: pops the scoreboard on every accepted output and checks hold stability.
  logic        held = 1'b0;
  logic [31:0] held_g;
  logic [32:0] e;
  always @(negedge clk_50) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", {31'd0, out_valid}, 1);
        chk("hold_gramme", out_gramme, held_g);
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got gramme 0x%08h, expected no output", out_gramme);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gramme", out_gramme, e[31:0]);
          chk("sb_stable", {31'd0, out_stable}, {31'd0, e[32]});
        end
        m_await = 1'b0;
        if (m_pend) begin
          m_pend = 1'b0;
          m_tare = 1'b1;
          blk.delete();
        end
      end else if (out_valid) begin
        held   = 1'b1;
        held_g = out_gramme;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  int          r;
  int          base;
  int          v;
  initial begin
    // 1: reset, tare at 1000, first measurement
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    chk_reset_values();
    model_reset();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_n(24'd1000, 3);
    chk("tare_busy_mid", {31'd0, tare_busy}, 1);
    send(24'd1000);
    chk("tare_busy_done", {31'd0, tare_busy}, 0);
    send_n(24'd1100, 4);
    expect_out("s1", 32'd15200, 1'b0);

    // 2: stable and unstable follow-ups
    send_n(24'd1105, 4);
    expect_out("s2a", 32'd15960, 1'b1);
    send_n(24'd1200, 4);
    expect_out("s2b", 32'd30400, 1'b0);

    // 3: negative net and full-scale negative sample
    send_n(24'd900, 4);
    expect_out("s3a", 32'hFFFFC4A0, 1'b0);
    send_n(24'h800000, 4);
    expect_out("s3b", 32'(-8389608 * 152), 1'b0);

    // 4: output held while consumer stalls; samples dropped
    out_ready = 1'b0;
    send_n(24'd2000, 4);
    chk("s4_valid", {31'd0, out_valid}, 1);
    chk("s4_gramme", out_gramme, 32'd152000);
    for (int i = 0; i < 8; i++) begin
      send(24'd2000);
      chk("s4_held_valid", {31'd0, out_valid}, 1);
      chk("s4_held_gramme", out_gramme, 32'd152000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s4_drop_valid", {31'd0, out_valid}, 0);
    chk("s4_queue", exp_q.size(), 0);
    out_ready = 1'b1;
    send_n(24'd1300, 4);
    expect_out("s4b", 32'd45600, 1'b0);

    // 5: tare request aborts a partial block
    send_n(24'd700, 2);
    tare_pulse();
    chk("s5_busy", {31'd0, tare_busy}, 1);
    send_n(24'd500, 4);
    chk("s5_busy_done", {31'd0, tare_busy}, 0);
    chk("s5_no_out", {31'd0, out_valid}, 0);
    send_n(24'd500, 4);
    expect_out("s5", 32'd0, 1'b0);

    // Randomized traffic with random backpressure and tare requests
    base = 5000;
    for (int i = 0; i < 800; i++) begin
      chk("rnd_tare_busy", {31'd0, tare_busy}, {31'd0, m_tare});
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) base = int'($urandom_range(0, 200000)) - 100000;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        tare_req  = 1'b1;
        smp_valid = 1'($urandom_range(0, 1));
        smp_data  = 24'($urandom);
        model_tare();
      end else if (r < 60) begin
        if (r < 40) v = base + int'($urandom_range(0, 20)) - 10;
        else v = int'($urandom);
        smp_valid = 1'b1;
        smp_data  = v[23:0];
        model_sample(v[23:0]);
      end
      tick();
      smp_valid = 1'b0;
      tare_req  = 1'b0;
    end
    drain();

    // 6: timeout fault, recovery, reset mid-block
    repeat (90) tick();
    chk("s6_no_fault", {31'd0, fault}, 0);
    repeat (15) tick();
    chk("s6_fault", {31'd0, fault}, 1);
    send(24'd500);
    chk("s6_fault_clear", {31'd0, fault}, 0);
    send(24'd500);
    drain();
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    tick();
    rst_n = 1'b1;
    send_n(24'd100, 4);
    send_n(24'd150, 4);
    expect_out("s6_post_reset", 32'd7600, 1'b0);

    tick();
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
